branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 103 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch lookup is combinational; decode resolves branches, redirects on mispredict and trains.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        IsBranchD,
  input  logic        BranchD,
  input  logic [31:0] PCBranchD,
  input  logic        PredTakenD,
  input  logic        StallD,
  output logic        RedirectF,
  output logic [31:0] RedirectPCF,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned TW  = 30 - IDX;

  logic          r_valid  [ENTRIES];
  logic [TW-1:0] r_tag    [ENTRIES];
  logic [31:0]   r_target [ENTRIES];
  logic [1:0]    r_ctr    [ENTRIES];
  logic [31:0]   r_branch_cnt;
  logic [31:0]   r_miss_cnt;

  logic [IDX-1:0] w_idx_f;
  logic [TW-1:0]  w_tag_f;
  logic           w_hit_f;
  logic [IDX-1:0] w_idx_d;
  logic [TW-1:0]  w_tag_d;
  logic           w_hit_d;
  logic           w_resolve;
  logic [1:0]     w_ctr_d;
  logic [1:0]     w_ctr_next;
  logic           w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^{PCF[1:0], PCD[1:0]};

  // Fetch-side lookup
  assign w_idx_f     = PCF[IDX+1:2];
  assign w_tag_f     = PCF[31:IDX+2];
  assign w_hit_f     = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign PredTakenF  = w_hit_f && r_ctr[w_idx_f][1];
  assign PredTargetF = PredTakenF ? r_target[w_idx_f] : PCF + 32'd4;

  // Decode-side resolution
  assign w_idx_d     = PCD[IDX+1:2];
  assign w_tag_d     = PCD[31:IDX+2];
  assign w_hit_d     = r_valid[w_idx_d] && (r_tag[w_idx_d] == w_tag_d);
  assign w_resolve   = IsBranchD && !StallD;
  assign RedirectF   = w_resolve && (BranchD != PredTakenD);
  assign RedirectPCF = BranchD ? PCBranchD : PCPlus4D;
  assign w_ctr_d     = r_ctr[w_idx_d];

  always_comb begin
    w_ctr_next = w_ctr_d;
    if (BranchD) begin
      if (w_ctr_d != 2'b11) w_ctr_next = w_ctr_d + 2'b01;
    end else begin
      if (w_ctr_d != 2'b00) w_ctr_next = w_ctr_d - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
      r_branch_cnt <= 32'd0;
      r_miss_cnt   <= 32'd0;
    end else if (w_resolve) begin
      r_branch_cnt <= r_branch_cnt + 32'd1;
      if (RedirectF) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_hit_d) begin
        r_ctr[w_idx_d] <= w_ctr_next;
      end else if (BranchD) begin
        r_valid[w_idx_d] <= 1'b1;
        r_ctr[w_idx_d]   <= 2'b10;
      end
    end
  end

  // Tag/target need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (w_resolve && BranchD) begin
      r_tag[w_idx_d]    <= w_tag_d;
      r_target[w_idx_d] <= PCBranchD;
    end
  end

  assign BranchCnt = r_branch_cnt;
  assign MissCnt   = r_miss_cnt;

endmodule
